// File: rtl/dbus_dmem.sv
// ============================================================================
// dbus_dmem: byte-strobed data RAM behind dbus, with a posted one-entry write
// buffer and forwarding reads. Optional tohost register: DBUS_SUB_TOHOST_EN. rev 1.0
// ============================================================================
`default_nettype none

module dbus_dmem #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           MEM_DEPTH   = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR = 32'h4000_0000
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    wvalid,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    arvalid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  output logic [DATA_WIDTH-1:0]   rdata,
  input  logic [ADDR_WIDTH-1:0]   addr
`ifdef DBUS_SUB_TOHOST_EN
  ,
  output logic [DATA_WIDTH-1:0]   tohost_o,
  output logic                    halt_o
`endif
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned OFF_W      = $clog2(STRB_WIDTH);
  localparam int unsigned IDX_W      = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH + 1)'(MEM_DEPTH * STRB_WIDTH);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                  pend_valid_q, pend_valid_d;
  logic [IDX_W-1:0]      pend_idx_q,   pend_idx_d;
  logic [DATA_WIDTH-1:0] pend_data_q,  pend_data_d;
  logic [STRB_WIDTH-1:0] pend_strb_q,  pend_strb_d;
  logic [DATA_WIDTH-1:0] rdata_q,      rdata_d;

  logic [ADDR_WIDTH-1:0] w_wr_off, w_rd_off;
  logic                  w_wr_in_range, w_rd_in_range;
  logic [IDX_W-1:0]      w_wr_idx, w_rd_idx;
  logic                  w_wr_tohost, w_rd_tohost;
  logic                  w_wr_load;
  logic [DATA_WIDTH-1:0] w_rd_merged;
  logic                  w_unused;

  // Unsigned subtraction wraps addresses below BASE_ADDR to huge offsets,
  // so one compare covers both range bounds.
  assign w_wr_off      = awaddr - BASE_ADDR;
  assign w_rd_off      = araddr - BASE_ADDR;
  assign w_wr_in_range = ({1'b0, w_wr_off} < MEM_BYTES);
  assign w_rd_in_range = ({1'b0, w_rd_off} < MEM_BYTES);
  assign w_wr_idx      = w_wr_off[OFF_W +: IDX_W];
  assign w_rd_idx      = w_rd_off[OFF_W +: IDX_W];

`ifdef DBUS_SUB_TOHOST_EN
  logic [DATA_WIDTH-1:0] tohost_q, tohost_d;
  logic                  halt_q,   halt_d;
  logic [DATA_WIDTH-1:0] w_tohost_merged;

  assign w_wr_tohost = wvalid && (awaddr == TOHOST_ADDR);
  assign w_rd_tohost = (araddr == TOHOST_ADDR);

  always_comb begin
    w_tohost_merged = tohost_q;
    for (int b = 0; b < STRB_WIDTH; b++) begin
      if (w_wr_tohost && wstrb[b]) w_tohost_merged[b*8 +: 8] = wdata[b*8 +: 8];
    end
    tohost_d = w_tohost_merged;
    halt_d   = halt_q | (w_wr_tohost & w_tohost_merged[0]);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tohost_q <= '0;
      halt_q   <= 1'b0;
    end else begin
      tohost_q <= tohost_d;
      halt_q   <= halt_d;
    end
  end

  assign tohost_o = tohost_q;
  assign halt_o   = halt_q;
  assign w_unused = ^{addr, w_wr_off, w_rd_off};
`else
  assign w_wr_tohost = 1'b0;
  assign w_rd_tohost = 1'b0;
  assign w_unused    = ^{addr, w_wr_off, w_rd_off, TOHOST_ADDR};
`endif

  assign w_wr_load = wvalid & w_wr_in_range & ~w_wr_tohost;

  always_comb begin
    pend_valid_d = w_wr_load;
    pend_idx_d   = pend_idx_q;
    pend_data_d  = pend_data_q;
    pend_strb_d  = pend_strb_q;
    if (w_wr_load) begin
      pend_idx_d  = w_wr_idx;
      pend_data_d = wdata;
      pend_strb_d = wstrb;
    end
  end

  // Per-byte forwarding: incoming write wins over the pending entry, then RAM.
  always_comb begin
    w_rd_merged = mem[w_rd_idx];
    for (int b = 0; b < STRB_WIDTH; b++) begin
      if (w_wr_load && (w_wr_idx == w_rd_idx) && wstrb[b]) begin
        w_rd_merged[b*8 +: 8] = wdata[b*8 +: 8];
      end else if (pend_valid_q && (pend_idx_q == w_rd_idx) && pend_strb_q[b]) begin
        w_rd_merged[b*8 +: 8] = pend_data_q[b*8 +: 8];
      end
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (arvalid) begin
      if (w_rd_tohost) begin
`ifdef DBUS_SUB_TOHOST_EN
        rdata_d = w_tohost_merged;
`else
        rdata_d = '0;
`endif
      end else if (w_rd_in_range) begin
        rdata_d = w_rd_merged;
      end else begin
        rdata_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_valid_q <= 1'b0;
      pend_idx_q   <= '0;
      pend_data_q  <= '0;
      pend_strb_q  <= '0;
      rdata_q      <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_idx_q   <= pend_idx_d;
      pend_data_q  <= pend_data_d;
      pend_strb_q  <= pend_strb_d;
      rdata_q      <= rdata_d;
    end
  end

  // Array is not reset; pend_valid_q is held low in reset so nothing commits.
  always_ff @(posedge clk_i) begin
    if (pend_valid_q) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (pend_strb_q[b]) mem[pend_idx_q][b*8 +: 8] <= pend_data_q[b*8 +: 8];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_dbus_dmem.sv
// ============================================================================
// tb_dbus_dmem: table-driven directed bench for dbus_dmem. rev 1.0
// ============================================================================
`default_nettype none

module tb_dbus_dmem;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] awaddr = '0;
  logic        wvalid = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        arvalid = 1'b0;
  logic [31:0] araddr = '0;
  logic [31:0] rdata;
  logic [31:0] addr = '0;
`ifdef DBUS_SUB_TOHOST_EN
  logic [31:0] tohost_o;
  logic        halt_o;
`endif

  int tests = 0;
  int failed = 0;

  always #5 clk_i = ~clk_i;

  dbus_dmem dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .awaddr  (awaddr),
    .wvalid  (wvalid),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .arvalid (arvalid),
    .araddr  (araddr),
    .rdata   (rdata),
    .addr    (addr)
`ifdef DBUS_SUB_TOHOST_EN
    ,
    .tohost_o(tohost_o),
    .halt_o  (halt_o)
`endif
  );

  typedef struct {
    logic        wv;
    logic [31:0] aw;
    logic [31:0] wd;
    logic [3:0]  ws;
    logic        rv;
    logic [31:0] ar;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic wv, input logic [31:0] aw, input logic [31:0] wd,
                     input logic [3:0] ws, input logic rv, input logic [31:0] ar,
                     input logic [31:0] exp);
    vec_t v;
    v.wv = wv; v.aw = aw; v.wd = wd; v.ws = ws;
    v.rv = rv; v.ar = ar; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Called at a negedge: drive, cross one active edge, return at the next negedge.
  task automatic cycle(input logic wv, input logic [31:0] aw, input logic [31:0] wd,
                       input logic [3:0] ws, input logic rv, input logic [31:0] ar);
    wvalid = wv; awaddr = aw; wdata = wd; wstrb = ws;
    arvalid = rv; araddr = ar;
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  initial begin
    //   wv  awaddr        wdata         ws    rv  araddr        expected rdata
    add(0, 32'h0,     32'h0,        4'h0, 0, 32'h0,     32'h0);        // 0 reset hold
    add(1, 32'h0,     32'hCAFEF00D, 4'hF, 0, 32'h0,     32'h0);        // 1
    add(1, 32'h10,    32'hDEADBEEF, 4'hF, 0, 32'h0,     32'h0);        // 2
    add(0, 32'h0,     32'h0,        4'h0, 0, 32'h0,     32'h0);        // 3
    add(0, 32'h0,     32'h0,        4'h0, 1, 32'h10,    32'hDEADBEEF); // 4 from RAM
    add(0, 32'h0,     32'h0,        4'h0, 1, 32'h0,     32'hCAFEF00D); // 5
    add(1, 32'h20,    32'h11223344, 4'hF, 0, 32'h0,     32'hCAFEF00D); // 6 hold
    add(1, 32'h20,    32'h000000AA, 4'h1, 1, 32'h20,    32'h112233AA); // 7 incoming over pending
    add(0, 32'h0,     32'h0,        4'h0, 1, 32'h20,    32'h112233AA); // 8 pending over RAM
    add(0, 32'h0,     32'h0,        4'h0, 1, 32'h20,    32'h112233AA); // 9 RAM
    add(1, 32'h30,    32'hFFFFFFFF, 4'hF, 0, 32'h0,     32'h112233AA); // 10
    add(0, 32'h0,     32'h0,        4'h0, 0, 32'h0,     32'h112233AA); // 11
    add(1, 32'h30,    32'h00005500, 4'h2, 0, 32'h0,     32'h112233AA); // 12
    add(0, 32'h0,     32'h0,        4'h0, 1, 32'h30,    32'hFFFF55FF); // 13 pending byte merge
    add(1, 32'h30,    32'h0,        4'h0, 1, 32'h30,    32'hFFFF55FF); // 14 strobe-less write
    add(0, 32'h0,     32'h0,        4'h0, 1, 32'h30,    32'hFFFF55FF); // 15 RAM unchanged
    add(1, 32'h4000,  32'h12345678, 4'hF, 1, 32'h4000,  32'h0);        // 16 out of range
    add(0, 32'h0,     32'h0,        4'h0, 1, 32'h0,     32'hCAFEF00D); // 17 no aliasing
    add(0, 32'h0,     32'h0,        4'h0, 1, 32'h4000,  32'h0);        // 18
    add(1, 32'h44,    32'hA5A5A5A5, 4'hF, 1, 32'h44,    32'hA5A5A5A5); // 19 write-before-read
    add(1, 32'h3FFC,  32'h87654321, 4'hF, 1, 32'h3FFC,  32'h87654321); // 20 last word
    add(0, 32'h0,     32'h0,        4'h0, 1, 32'h3FFC,  32'h87654321); // 21
    add(0, 32'h0,     32'h0,        4'h0, 0, 32'h0,     32'h87654321); // 22 hold
    add(1, 32'h50,    32'h01020304, 4'hF, 0, 32'h0,     32'h87654321); // 23
    add(1, 32'h54,    32'h05060708, 4'hF, 1, 32'h50,    32'h01020304); // 24 back-to-back
    add(0, 32'h0,     32'h0,        4'h0, 1, 32'h54,    32'h05060708); // 25
    add(0, 32'h0,     32'h0,        4'h0, 1, 32'h50,    32'h01020304); // 26
    add(1, 32'h60,    32'h11111111, 4'hF, 0, 32'h0,     32'h01020304); // 27
    add(0, 32'h0,     32'h0,        4'h0, 1, 32'h60,    32'h11111111); // 28

    repeat (3) @(negedge clk_i);
    check("reset_rdata", rdata, 32'h0);
`ifdef DBUS_SUB_TOHOST_EN
    check("reset_tohost", tohost_o, 32'h0);
    check("reset_halt", {31'b0, halt_o}, 32'h0);
`endif
    rst_ni = 1'b1;
    @(negedge clk_i);

    foreach (vecs[i]) begin
      cycle(vecs[i].wv, vecs[i].aw, vecs[i].wd, vecs[i].ws, vecs[i].rv, vecs[i].ar);
      check($sformatf("vec%0d", i), rdata, vecs[i].exp);
    end

`ifdef DBUS_SUB_TOHOST_EN
    cycle(1, 32'h4000_0000, 32'h1, 4'hF, 1, 32'h4000_0000);
    check("tohost_val", tohost_o, 32'h1);
    check("tohost_halt", {31'b0, halt_o}, 32'h1);
    check("tohost_read_fwd", rdata, 32'h1);
    cycle(1, 32'h4000_0000, 32'h0, 4'hF, 1, 32'h0);
    check("tohost_clear", tohost_o, 32'h0);
    check("halt_sticky", {31'b0, halt_o}, 32'h1);
    check("tohost_ram_untouched", rdata, 32'hCAFEF00D);
`endif

    // Post a write, then reset before it can commit.
    cycle(1, 32'h60, 32'h77777777, 4'hF, 0, 32'h0);
    wvalid = 1'b0; arvalid = 1'b0;
    rst_ni = 1'b0;
    #1;
    check("midreset_rdata", rdata, 32'h0);
`ifdef DBUS_SUB_TOHOST_EN
    check("midreset_halt", {31'b0, halt_o}, 32'h0);
    check("midreset_tohost", tohost_o, 32'h0);
`endif
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    cycle(0, 32'h0, 32'h0, 4'h0, 1, 32'h60);
    check("pending_discarded", rdata, 32'h11111111);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
